wordle_scorer: RTL and testbench

Duplicate-aware guess scoring engine for the Wordle design, placed downstream of the game state machine and upstream of the VGA tile renderer. On a start edge it compares a five-letter guess against the answer. It classifies each letter as green, yellow, or gray using standard Wordle duplicate rules, and commits the colours into an internal 6×5 colour store. The renderer reads that store combinationally, which replaces per-state colour logic in the top level.

---
 rtl/wordle_scorer_if.sv | 26 ++
 rtl/wordle_scorer.sv | 183 ++++++++++++++++++
 tb/tb_wordle_scorer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wordle_scorer_if.sv
// Scoring request, status and renderer read bus between the game FSM / VGA
// renderer (master) and the guess scorer (slave).
interface wordle_scorer_if;
    logic        start;
    logic        clear;
    logic [39:0] guess;
    logic [39:0] answer;
    logic [2:0]  row;
    logic        busy;
    logic        done;
    logic        win;
    logic        err;
    logic [2:0]  rd_row;
    logic [2:0]  rd_col;
    logic [1:0]  rd_color;

    modport master (
        output start, clear, guess, answer, row, rd_row, rd_col,
        input  busy, done, win, err, rd_color
    );

    modport slave (
        input  start, clear, guess, answer, row, rd_row, rd_col,
        output busy, done, win, err, rd_color
    );
endinterface

// File: rtl/wordle_scorer.sv
// Duplicate-aware Wordle guess scorer with an internal ROWS x 5 colour store.
// A start edge runs a fixed 16-cycle sequence: 5 green passes, 5 yellow
// passes, 5 store writes, then a one-cycle done.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for a start edge; win holds the last result
// S_GREEN  | idx 0..4: exact-position matches, mark green and consume answer
// S_YELLOW | idx 0..4: lowest unconsumed matching answer letter -> yellow
// S_COMMIT | idx 0..4: write colour of letter idx into store[row_q]
// S_DONE   | one cycle, done pulse is high, then back to idle
module wordle_scorer #(
    parameter int ROWS = 6
) (
    input logic             board_clk,
    input logic             reset,
    wordle_scorer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t      state;
    logic        start_d;
    logic [7:0]  g_q [5];
    logic [7:0]  a_q [5];
    logic [2:0]  row_q;
    logic [4:0]  green;
    logic [4:0]  yellow;
    logic [4:0]  used;
    logic [2:0]  idx;
    logic [1:0]  store [ROWS][5];
    logic        busy_q;
    logic        done_q;
    logic        win_q;
    logic        err_q;

    logic        start_edge;
    logic        row_ok;
    logic        y_hit;
    logic [2:0]  y_j;

    assign start_edge = bus.start & ~start_d;
    assign row_ok     = int'(bus.row) < ROWS;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.win  = win_q;
    assign bus.err  = err_q;

    // Lowest unconsumed answer position matching the current guess letter;
    // scanning downward lets the lowest hit overwrite higher ones.
    always_comb begin
        y_hit = 1'b0;
        y_j   = 3'd0;
        for (int j = 4; j >= 0; j--) begin
            if (!used[j] && (a_q[j] == g_q[idx])) begin
                y_hit = 1'b1;
                y_j   = 3'(j);
            end
        end
    end

    // Renderer read port; out-of-range coordinates read as empty.
    always_comb begin
        bus.rd_color = 2'b00;
        if ((int'(bus.rd_row) < ROWS) && (bus.rd_col < 3'd5)) begin
            bus.rd_color = store[bus.rd_row][bus.rd_col];
        end
    end

    // Scoring sequencer, colour store and registered status outputs.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            start_d <= 1'b0;
            row_q   <= 3'd0;
            green   <= 5'd0;
            yellow  <= 5'd0;
            used    <= 5'd0;
            idx     <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                g_q[k] <= 8'd0;
                a_q[k] <= 8'd0;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < 5; c++) begin
                    store[r][c] <= 2'b00;
                end
            end
        end else begin
            start_d <= bus.start;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (bus.clear) begin
                // clear takes priority over any start edge in the same cycle
                state  <= S_IDLE;
                idx    <= 3'd0;
                busy_q <= 1'b0;
                win_q  <= 1'b0;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < 5; c++) begin
                        store[r][c] <= 2'b00;
                    end
                end
            end else begin
                err_q <= start_edge && ((state != S_IDLE) || !row_ok);
                case (state)
                    S_IDLE: begin
                        if (start_edge && row_ok) begin
                            for (int k = 0; k < 5; k++) begin
                                g_q[k] <= bus.guess[39-8*k -: 8];
                                a_q[k] <= bus.answer[39-8*k -: 8];
                            end
                            row_q  <= bus.row;
                            green  <= 5'd0;
                            yellow <= 5'd0;
                            used   <= 5'd0;
                            idx    <= 3'd0;
                            busy_q <= 1'b1;
                            win_q  <= 1'b0;
                            state  <= S_GREEN;
                        end
                    end
                    S_GREEN: begin
                        if (g_q[idx] == a_q[idx]) begin
                            green[idx] <= 1'b1;
                            used[idx]  <= 1'b1;
                        end
                        if (idx == 3'd4) begin
                            idx   <= 3'd0;
                            state <= S_YELLOW;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    S_YELLOW: begin
                        if (!green[idx] && y_hit) begin
                            yellow[idx] <= 1'b1;
                            used[y_j]   <= 1'b1;
                        end
                        if (idx == 3'd4) begin
                            idx   <= 3'd0;
                            state <= S_COMMIT;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    S_COMMIT: begin
                        store[row_q][idx] <= green[idx]  ? 2'b11 :
                                             yellow[idx] ? 2'b10 : 2'b01;
                        if (idx == 3'd4) begin
                            idx    <= 3'd0;
                            done_q <= 1'b1;
                            win_q  <= &green;
                            state  <= S_DONE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    S_DONE: begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wordle_scorer.sv
// Directed bench for wordle_scorer: hand-scored guesses, edge/err handling,
// clear and reset aborts, and renderer read boundaries.
module tb_wordle_scorer;

    logic board_clk;
    logic reset;
    int   errors;
    int   checks;

    wordle_scorer_if bus ();

    wordle_scorer #(.ROWS(6)) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge board_clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] r, input logic [2:0] c, output logic [1:0] v);
        bus.rd_row = r;
        bus.rd_col = c;
        #1;
        v = bus.rd_color;
    endtask

    // exp packs letter 0 in [9:8] down to letter 4 in [1:0]
    task automatic check_row(input string tag, input logic [2:0] r, input logic [9:0] exp);
        logic [1:0] v;
        for (int c = 0; c < 5; c++) begin
            rd(r, 3'(c), v);
            check($sformatf("%s_c%0d", tag, c), 32'(v), 32'(exp[9-2*c -: 2]));
        end
    endtask

    // Drives a start rising edge; returns just after E0.
    task automatic start_op(input logic [39:0] g, input logic [39:0] a, input logic [2:0] r);
        @(negedge board_clk);
        bus.guess  = g;
        bus.answer = a;
        bus.row    = r;
        bus.start  = 1'b1;
        tick();
    endtask

    task automatic run_op(input string tag, input logic [39:0] g, input logic [39:0] a,
                          input logic [2:0] r);
        logic seen;
        seen = 1'b0;
        start_op(g, a, r);
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge board_clk);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [1:0] v;
        int done_cnt;
        int done_at;
        logic busy_e0, busy_e15, busy_e16;
        logic [1:0] col_e10, col_e11;
        logic seen;

        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.guess = '0;
        bus.answer = '0;
        bus.row = '0;
        bus.rd_row = '0;
        bus.rd_col = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_win", 32'(bus.win), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check_row("rst_row0", 3'd0, 10'b00_00_00_00_00);
        @(negedge board_clk);
        reset = 1'b0;
        tick();

        // CRANE/CRANE row 0, start held high 200 cycles
        bus.rd_row = 3'd0;
        bus.rd_col = 3'd0;
        done_cnt = 0;
        done_at = -1;
        start_op("CRANE", "CRANE", 3'd0);
        busy_e0 = bus.busy;
        busy_e15 = 1'b0;
        busy_e16 = 1'b1;
        col_e10 = 2'bxx;
        col_e11 = 2'bxx;
        for (int cyc = 1; cyc < 200; cyc++) begin
            tick();
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (cyc == 10) col_e10 = bus.rd_color;
            if (cyc == 11) col_e11 = bus.rd_color;
            if (cyc == 15) busy_e15 = bus.busy;
            if (cyc == 16) busy_e16 = bus.busy;
        end
        check("t1_done_count", 32'(done_cnt), 32'd1);
        // done follows E15, i.e. the 16th edge counting the sampling edge
        check("t1_done_edge", 32'(done_at), 32'd15);
        check("t1_busy_e0", 32'(busy_e0), 32'd1);
        check("t1_busy_e15", 32'(busy_e15), 32'd1);
        check("t1_busy_e16", 32'(busy_e16), 32'd0);
        check("t1_col_e10", 32'(col_e10), 32'd0);
        check("t1_col_e11", 32'(col_e11), 32'd3);
        check("t1_win", 32'(bus.win), 32'd1);
        check_row("t1_row0", 3'd0, 10'b11_11_11_11_11);
        rd(3'd0, 3'd5, v);
        check("t1_rd_col5", 32'(v), 32'd0);
        rd(3'd6, 3'd0, v);
        check("t1_rd_row6", 32'(v), 32'd0);
        @(negedge board_clk);
        bus.start = 1'b0;
        tick();

        // Duplicate handling
        run_op("t2", "PAPAL", "APPLE", 3'd1);
        check("t2_win", 32'(bus.win), 32'd0);
        check_row("t2_row1", 3'd1, 10'b10_10_11_01_10);
        run_op("t3", "EERIE", "CRANE", 3'd2);
        check_row("t3_row2", 3'd2, 10'b01_01_10_01_11);
        run_op("t4", "BUMPY", "CRANE", 3'd5);
        check_row("t4_row5", 3'd5, 10'b01_01_01_01_01);
        check_row("t4_row0", 3'd0, 10'b11_11_11_11_11);
        check_row("t4_row1", 3'd1, 10'b10_10_11_01_10);
        check_row("t4_row2", 3'd2, 10'b01_01_10_01_11);
        check_row("t4_row3", 3'd3, 10'b00_00_00_00_00);
        check_row("t4_row4", 3'd4, 10'b00_00_00_00_00);

        // Rejected start, row out of range
        start_op("CRANE", "CRANE", 3'd6);
        check("t5_err", 32'(bus.err), 32'd1);
        check("t5_busy", 32'(bus.busy), 32'd0);
        tick();
        check("t5_err_gone", 32'(bus.err), 32'd0);
        check("t5_busy2", 32'(bus.busy), 32'd0);
        @(negedge board_clk);
        bus.start = 1'b0;
        tick();
        check_row("t5_row0", 3'd0, 10'b11_11_11_11_11);
        check_row("t5_row5", 3'd5, 10'b01_01_01_01_01);

        // Second start edge at E5 while busy
        start_op("CRANE", "CRANE", 3'd3);
        @(negedge board_clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        @(negedge board_clk);
        bus.start = 1'b1;
        bus.row = 3'd4;
        tick();
        check("t6_err", 32'(bus.err), 32'd1);
        check("t6_busy", 32'(bus.busy), 32'd1);
        @(negedge board_clk);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check("t6_done_seen", 32'(seen), 32'd1);
        check("t6_win", 32'(bus.win), 32'd1);
        check_row("t6_row3", 3'd3, 10'b11_11_11_11_11);
        check_row("t6_row4", 3'd4, 10'b00_00_00_00_00);

        // clear at E8
        start_op("BUMPY", "CRANE", 3'd4);
        @(negedge board_clk);
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        @(negedge board_clk);
        bus.clear = 1'b1;
        tick();
        check("t7_busy", 32'(bus.busy), 32'd0);
        check("t7_win", 32'(bus.win), 32'd0);
        @(negedge board_clk);
        bus.clear = 1'b0;
        check_row("t7_row0", 3'd0, 10'b00_00_00_00_00);
        check_row("t7_row3", 3'd3, 10'b00_00_00_00_00);
        check_row("t7_row5", 3'd5, 10'b00_00_00_00_00);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("t7_no_done", 32'(done_cnt), 32'd0);
        check_row("t7_row4", 3'd4, 10'b00_00_00_00_00);

        // reset at E12
        run_op("t8a", "CRANE", "CRANE", 3'd0);
        check("t8_win_pre", 32'(bus.win), 32'd1);
        start_op("CRANE", "CRANE", 3'd1);
        @(negedge board_clk);
        bus.start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        rd(3'd1, 3'd0, v);
        check("t8_row1_c0_e11", 32'(v), 32'd3);
        rd(3'd1, 3'd1, v);
        check("t8_row1_c1_e11", 32'(v), 32'd0);
        reset = 1'b1;
        #1;
        check("t8_busy", 32'(bus.busy), 32'd0);
        check("t8_done", 32'(bus.done), 32'd0);
        check("t8_win", 32'(bus.win), 32'd0);
        check("t8_err", 32'(bus.err), 32'd0);
        check_row("t8_row0", 3'd0, 10'b00_00_00_00_00);
        check_row("t8_row1", 3'd1, 10'b00_00_00_00_00);
        @(negedge board_clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("t8_no_done", 32'(done_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
